// File: rtl/uart_time_parser_pkg.sv
// Shared definitions for the UART time-frame parser and the time-to-ASCII formatter.
package uart_time_parser_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_T_UP  = 8'h54;
  localparam logic [7:0] ASCII_T_LO  = 8'h74;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam int unsigned FIELD_W = 6;

  typedef enum logic [3:0] {
    IDLE, H1, H0, C1, M1, M0, C2, S1, S0, END
  } parse_state_t;

  // Two BCD-style digits to a binary field, kept 7 bits wide so that
  // out-of-range values such as 99 survive for the range check.
  function automatic logic [6:0] field_val(input logic [3:0] tens,
                                           input logic [3:0] ones);
    return ({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/uart_time_parser_ascii_classifier.sv
// Combinational byte classifier for the time-frame parser.
module ascii_classifier
  import uart_time_parser_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_digit_o,
  output logic       is_colon_o,
  output logic       is_start_o,
  output logic       is_term_o,
  output logic [3:0] digit_val_o
);

  // Decode the byte into the character classes used by the frame grammar.
  always_comb begin
    is_digit_o  = (byte_i >= ASCII_0) && (byte_i <= ASCII_9);
    is_colon_o  = (byte_i == ASCII_COLON);
    is_start_o  = (byte_i == ASCII_T_UP) || (byte_i == ASCII_T_LO);
    is_term_o   = (byte_i == ASCII_CR) || (byte_i == ASCII_LF);
    digit_val_o = byte_i[3:0];
  end

endmodule

// File: rtl/uart_time_parser.sv
// Parses "T" HH ":" MM ":" SS <CR|LF> frames from the UART RX FIFO into a
// one-cycle time-load pulse. Optional inter-byte timeout: PARSE_TIMEOUT_EN.
module uart_time_parser
  import uart_time_parser_pkg::*;
#(
  parameter int unsigned HOUR      = 24,
  parameter int unsigned SECOND_60 = 60
`ifdef PARSE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 100_000_000
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_empty,
  input  logic [7:0]         i_data,
  output logic               o_re,
  output logic               o_set,
  output logic [FIELD_W-1:0] o_hour,
  output logic [FIELD_W-1:0] o_min,
  output logic [FIELD_W-1:0] o_sec,
  output logic               o_error,
  output logic               o_busy
);

  logic               is_digit, is_colon, is_start, is_term;
  logic [3:0]         digit_val;
  logic               consume;
  logic               bad;
  logic [6:0]         hour_f, min_f, sec_f;

  parse_state_t       state_q, state_d;
  logic [5:0][3:0]    dig_q, dig_d;
  logic [FIELD_W-1:0] hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic               set_q, set_d, err_q, err_d;

`ifdef PARSE_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  ascii_classifier u_class (
    .byte_i      (i_data),
    .is_digit_o  (is_digit),
    .is_colon_o  (is_colon),
    .is_start_o  (is_start),
    .is_term_o   (is_term),
    .digit_val_o (digit_val)
  );

  assign consume = ~i_empty;
  assign o_re    = consume;
  assign o_set   = set_q;
  assign o_error = err_q;
  assign o_hour  = hour_q;
  assign o_min   = min_q;
  assign o_sec   = sec_q;
  assign o_busy  = (state_q != IDLE);

  assign hour_f = field_val(dig_q[0], dig_q[1]);
  assign min_f  = field_val(dig_q[2], dig_q[3]);
  assign sec_f  = field_val(dig_q[4], dig_q[5]);

  // Next-state, digit capture, range check and pulse generation.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    set_d   = 1'b0;
    err_d   = 1'b0;
    bad     = 1'b0;
`ifdef PARSE_TIMEOUT_EN
    cnt_d   = '0;
`endif
    if (consume) begin
      case (state_q)
        IDLE: if (is_start) state_d = H1;
        H1:   if (is_digit) begin dig_d[0] = digit_val; state_d = H0; end else bad = 1'b1;
        H0:   if (is_digit) begin dig_d[1] = digit_val; state_d = C1; end else bad = 1'b1;
        C1:   if (is_colon) state_d = M1; else bad = 1'b1;
        M1:   if (is_digit) begin dig_d[2] = digit_val; state_d = M0; end else bad = 1'b1;
        M0:   if (is_digit) begin dig_d[3] = digit_val; state_d = C2; end else bad = 1'b1;
        C2:   if (is_colon) state_d = S1; else bad = 1'b1;
        S1:   if (is_digit) begin dig_d[4] = digit_val; state_d = S0; end else bad = 1'b1;
        S0:   if (is_digit) begin dig_d[5] = digit_val; state_d = END; end else bad = 1'b1;
        END: begin
          if (is_term) begin
            state_d = IDLE;
            if ((hour_f < 7'(HOUR)) && (min_f < 7'(SECOND_60)) && (sec_f < 7'(SECOND_60))) begin
              hour_d = hour_f[FIELD_W-1:0];
              min_d  = min_f[FIELD_W-1:0];
              sec_d  = sec_f[FIELD_W-1:0];
              set_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            bad = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      // A stray start byte aborts the current frame and opens a new one.
      if (bad) begin
        err_d   = 1'b1;
        state_d = is_start ? H1 : IDLE;
      end
    end
`ifdef PARSE_TIMEOUT_EN
    else if (state_q != IDLE) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // State, digit, output and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dig_q   <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      set_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef PARSE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      set_q   <= set_d;
      err_q   <= err_d;
`ifdef PARSE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_time_parser.sv
// Self-checking bench for uart_time_parser (default build).
module tb_uart_time_parser;

  logic       clk = 1'b0;
  logic       rst, i_empty;
  logic [7:0] i_data;
  logic       o_re, o_set, o_error, o_busy;
  logic [5:0] o_hour, o_min, o_sec;

  always #5 clk = ~clk;

  uart_time_parser dut (
    .clk     (clk),
    .rst     (rst),
    .i_empty (i_empty),
    .i_data  (i_data),
    .o_re    (o_re),
    .o_set   (o_set),
    .o_hour  (o_hour),
    .o_min   (o_min),
    .o_sec   (o_sec),
    .o_error (o_error),
    .o_busy  (o_busy)
  );

  int n_vec = 0;
  int n_fail = 0;
  int set_cnt = 0;
  int err_cnt = 0;

  // Frame model: text received since the last start character.
  bit             in_frame = 1'b0;
  byte unsigned   fbuf[$];
  bit             exp_set = 1'b0;
  bit             exp_err = 1'b0;
  int             exp_h = 0, exp_m = 0, exp_s = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int dval(input byte unsigned b);
    return int'(b) - 48;
  endfunction

  function automatic void consume(input byte unsigned b);
    bit st, ok;
    int pos, h, m, s;
    st = (b == 8'h54) || (b == 8'h74);
    if (!in_frame) begin
      if (st) begin
        in_frame = 1'b1;
        fbuf.delete();
      end
      return;
    end
    pos = fbuf.size();
    if (pos == 8) ok = (b == 8'h0D) || (b == 8'h0A);
    else if (pos == 2 || pos == 5) ok = (b == 8'h3A);
    else ok = (b >= 8'h30) && (b <= 8'h39);
    if (!ok) begin
      exp_err = 1'b1;
      if (st) fbuf.delete();
      else in_frame = 1'b0;
    end else if (pos == 8) begin
      h = dval(fbuf[0]) * 10 + dval(fbuf[1]);
      m = dval(fbuf[3]) * 10 + dval(fbuf[4]);
      s = dval(fbuf[6]) * 10 + dval(fbuf[7]);
      if (h < 24 && m < 60 && s < 60) begin
        exp_set = 1'b1;
        exp_h = h; exp_m = m; exp_s = s;
      end else begin
        exp_err = 1'b1;
      end
      in_frame = 1'b0;
    end else begin
      fbuf.push_back(b);
    end
  endfunction

  // Advance the model on each edge, then compare all outputs just after it.
  always @(posedge clk) begin
    exp_set = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      in_frame = 1'b0;
      fbuf.delete();
      exp_h = 0; exp_m = 0; exp_s = 0;
    end else if (!i_empty) begin
      consume(i_data);
    end
    #1;
    chk("re",    o_re,    !i_empty);
    chk("set",   o_set,   exp_set);
    chk("error", o_error, exp_err);
    chk("hour",  o_hour,  exp_h);
    chk("min",   o_min,   exp_m);
    chk("sec",   o_sec,   exp_s);
    chk("busy",  o_busy,  in_frame);
    if (o_set) set_cnt++;
    if (o_error) err_cnt++;
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      i_empty = 1'b0;
      i_data  = s[i];
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    i_empty = 1'b0;
    i_data  = b;
  endtask

  // FIFO empty; head byte deliberately looks like a start character.
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      i_empty = 1'b1;
      i_data  = 8'h54;
    end
  endtask

  task automatic expect_result(input string name, input int s0, input int e0,
                               input int dset, input int derr,
                               input int h, input int m, input int s);
    gap(3);
    chk({name, "_nset"}, set_cnt - s0, dset);
    chk({name, "_nerr"}, err_cnt - e0, derr);
    chk({name, "_h"}, o_hour, h);
    chk({name, "_m"}, o_min, m);
    chk({name, "_s"}, o_sec, s);
    chk({name, "_busy"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, e0;
    rst = 1'b1; i_empty = 1'b1; i_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_h", o_hour, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_set", o_set, 0);

    // Valid frame, set pulse exactly one cycle after CR.
    s0 = set_cnt; e0 = err_cnt;
    send("T12:34:56");
    send_byte(8'h0D);
    @(negedge clk); i_empty = 1'b1;
    chk("lat_set", o_set, 1);
    expect_result("f1", s0, e0, 1, 0, 12, 34, 56);

    // Hour out of range.
    s0 = set_cnt; e0 = err_cnt;
    send("T24:00:00");
    send_byte(8'h0A);
    @(negedge clk); i_empty = 1'b1;
    chk("lat_err", o_error, 1);
    expect_result("f2", s0, e0, 0, 1, 12, 34, 56);

    // Bad digit, then a good frame back-to-back.
    s0 = set_cnt; e0 = err_cnt;
    send("T1xT08:05:09");
    send_byte(8'h0A);
    expect_result("f3", s0, e0, 1, 1, 8, 5, 9);

    // Start character mid-frame resyncs.
    s0 = set_cnt; e0 = err_cnt;
    send("T12:3T23:59:59");
    send_byte(8'h0D);
    expect_result("f4", s0, e0, 1, 1, 23, 59, 59);

    // Junk in idle is silent; second out of range; lowercase start.
    s0 = set_cnt; e0 = err_cnt;
    send("9:x");
    send_byte(8'h0D);
    send("t00:00:60");
    send_byte(8'h0D);
    send("t19:00:07");
    send_byte(8'h0A);
    expect_result("f5", s0, e0, 1, 1, 19, 0, 7);

    // Long empty stretch mid-frame waits without timing out.
    s0 = set_cnt; e0 = err_cnt;
    send("T10:");
    gap(50);
    chk("stall_busy", o_busy, 1);
    send("20:30");
    send_byte(8'h0A);
    expect_result("f6", s0, e0, 1, 0, 10, 20, 30);

    // Reset mid-frame discards it; remainder is ignored.
    s0 = set_cnt; e0 = err_cnt;
    send("T11:22");
    @(negedge clk); rst = 1'b1; i_empty = 1'b1;
    @(negedge clk); rst = 1'b0;
    send(":33");
    send_byte(8'h0A);
    expect_result("f7", s0, e0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
